// File: rtl/mpram_port_sched_if.sv
// Request/response and RAM-side bus bundle for mpram_port_sched.
// master: request source plus RAM read data; slave: the scheduler.
interface mpram_port_sched_if #(
  parameter int MD = 16,
  parameter int DW = 32,
  parameter int nP = 2
) ();
  localparam int AW = $clog2(MD);

  logic [nP-1:0]    reqValid;
  logic [nP-1:0]    reqReady;
  logic [nP-1:0]    reqWr;
  logic [AW*nP-1:0] reqAddr;
  logic [DW*nP-1:0] reqData;
  logic [nP-1:0]    rspValid;
  logic [DW*nP-1:0] rspData;
  logic [nP-1:0]    wrRd;
  logic [nP-1:0]    wEn;
  logic [AW*nP-1:0] wAddr;
  logic [DW*nP-1:0] wData;
  logic [AW*nP-1:0] rAddr;
  logic [DW*nP-1:0] rData;
  logic [15:0]      cflCnt;

  modport master (
    output reqValid, reqWr, reqAddr, reqData, rData,
    input  reqReady, rspValid, rspData, wrRd, wEn, wAddr, wData, rAddr, cflCnt
  );

  modport slave (
    input  reqValid, reqWr, reqAddr, reqData, rData,
    output reqReady, rspValid, rspData, wrRd, wEn, wAddr, wData, rAddr, cflCnt
  );
endinterface

// File: rtl/mpram_port_sched.sv
// Per-port request FIFOs feeding a registered issue stage for a switched-port
// LVT multiported RAM. Same-address writes from several ports in one cycle are
// serialised by port index; issued reads are tracked so the returning rData
// is flagged with rspValid after the RAM read latency.
module mpram_port_sched #(
  parameter int MD  = 16,
  parameter int DW  = 32,
  parameter int nP  = 2,
  parameter int DEP = 4,
  parameter int RL  = 1
) (
  input  logic              clk,
  input  logic              rst,
  mpram_port_sched_if.slave bus
);
  localparam int AW = $clog2(MD);
  localparam int PW = $clog2(DEP);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(nP) + 1;

  logic          fifo_wr_q   [nP][DEP];
  logic [AW-1:0] fifo_addr_q [nP][DEP];
  logic [DW-1:0] fifo_data_q [nP][DEP];
  logic [PW-1:0] wptr_q [nP];
  logic [PW-1:0] wptr_d [nP];
  logic [PW-1:0] rptr_q [nP];
  logic [PW-1:0] rptr_d [nP];
  logic [CW-1:0] cnt_q  [nP];
  logic [CW-1:0] cnt_d  [nP];

  logic          head_wr   [nP];
  logic [AW-1:0] head_addr [nP];
  logic [DW-1:0] head_data [nP];
  logic [nP-1:0] ready;
  logic [nP-1:0] push;
  logic [nP-1:0] nonempty;
  logic [nP-1:0] stall;
  logic [nP-1:0] issue;
  logic [SW-1:0] stall_cnt;

  logic [nP-1:0] wr_rd_q, wr_rd_d;
  logic [nP-1:0] wen_q, wen_d;
  logic [nP-1:0] rd_iss_q, rd_iss_d;
  logic [AW-1:0] waddr_q [nP];
  logic [AW-1:0] waddr_d [nP];
  logic [AW-1:0] raddr_q [nP];
  logic [AW-1:0] raddr_d [nP];
  logic [DW-1:0] wdata_q [nP];
  logic [DW-1:0] wdata_d [nP];
  logic [RL-1:0] rsp_pipe_q [nP];
  logic [RL-1:0] rsp_pipe_d [nP];
  logic [15:0]   cfl_q, cfl_d;
  logic [16:0]   cfl_sum;

  // FIFO status, head entry and accept handshake (ready forced low in reset)
  always_comb begin
    ready    = '0;
    push     = '0;
    nonempty = '0;
    for (int p = 0; p < nP; p++) begin
      nonempty[p]  = (cnt_q[p] != '0);
      ready[p]     = (cnt_q[p] != CW'(DEP)) && !rst;
      push[p]      = bus.reqValid[p] && ready[p];
      head_wr[p]   = fifo_wr_q[p][rptr_q[p]];
      head_addr[p] = fifo_addr_q[p][rptr_q[p]];
      head_data[p] = fifo_data_q[p][rptr_q[p]];
    end
  end

  // Write-collision arbitration: the lowest-indexed writer to an address wins
  always_comb begin
    stall     = '0;
    issue     = '0;
    stall_cnt = '0;
    for (int p = 0; p < nP; p++) begin
      for (int q = 0; q < p; q++) begin
        if (nonempty[p] && head_wr[p] && nonempty[q] && head_wr[q] &&
            (head_addr[q] == head_addr[p]))
          stall[p] = 1'b1;
      end
      issue[p]  = nonempty[p] && !stall[p];
      stall_cnt = stall_cnt + SW'(stall[p]);
    end
  end

  // FIFO pointer/occupancy and saturating stall-counter next state
  always_comb begin
    for (int p = 0; p < nP; p++) begin
      wptr_d[p] = push[p]  ? wptr_q[p] + 1'b1 : wptr_q[p];
      rptr_d[p] = issue[p] ? rptr_q[p] + 1'b1 : rptr_q[p];
      cnt_d[p]  = cnt_q[p] + CW'(push[p]) - CW'(issue[p]);
    end
    cfl_sum = {1'b0, cfl_q} + 17'(stall_cnt);
    cfl_d   = cfl_sum[16] ? 16'hFFFF : cfl_sum[15:0];
  end

  // Issue register next state; idle slots hold address/data
  always_comb begin
    wr_rd_d  = '0;
    wen_d    = '0;
    rd_iss_d = '0;
    for (int p = 0; p < nP; p++) begin
      waddr_d[p]    = waddr_q[p];
      raddr_d[p]    = raddr_q[p];
      wdata_d[p]    = wdata_q[p];
      rsp_pipe_d[p] = (rsp_pipe_q[p] << 1) | RL'(rd_iss_q[p]);
      if (issue[p]) begin
        raddr_d[p] = head_addr[p];
        if (head_wr[p]) begin
          wr_rd_d[p] = 1'b1;
          wen_d[p]   = 1'b1;
          waddr_d[p] = head_addr[p];
          wdata_d[p] = head_data[p];
        end else begin
          rd_iss_d[p] = 1'b1;
        end
      end
    end
  end

  // Control, issue and response-tracking registers
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_rd_q  <= '0;
      wen_q    <= '0;
      rd_iss_q <= '0;
      cfl_q    <= '0;
      for (int p = 0; p < nP; p++) begin
        wptr_q[p]     <= '0;
        rptr_q[p]     <= '0;
        cnt_q[p]      <= '0;
        waddr_q[p]    <= '0;
        raddr_q[p]    <= '0;
        wdata_q[p]    <= '0;
        rsp_pipe_q[p] <= '0;
      end
    end else begin
      wr_rd_q  <= wr_rd_d;
      wen_q    <= wen_d;
      rd_iss_q <= rd_iss_d;
      cfl_q    <= cfl_d;
      for (int p = 0; p < nP; p++) begin
        wptr_q[p]     <= wptr_d[p];
        rptr_q[p]     <= rptr_d[p];
        cnt_q[p]      <= cnt_d[p];
        waddr_q[p]    <= waddr_d[p];
        raddr_q[p]    <= raddr_d[p];
        wdata_q[p]    <= wdata_d[p];
        rsp_pipe_q[p] <= rsp_pipe_d[p];
      end
    end
  end

  // FIFO storage; pushes never happen in reset because ready is low
  always_ff @(posedge clk) begin
    for (int p = 0; p < nP; p++) begin
      if (push[p]) begin
        fifo_wr_q[p][wptr_q[p]]   <= bus.reqWr[p];
        fifo_addr_q[p][wptr_q[p]] <= bus.reqAddr[p*AW +: AW];
        fifo_data_q[p][wptr_q[p]] <= bus.reqData[p*DW +: DW];
      end
    end
  end

  // Pack per-port registers onto the bus; read data passes straight through
  always_comb begin
    bus.reqReady = ready;
    bus.wrRd     = wr_rd_q;
    bus.wEn      = wen_q;
    bus.rspValid = '0;
    bus.wAddr    = '0;
    bus.rAddr    = '0;
    bus.wData    = '0;
    for (int p = 0; p < nP; p++) begin
      bus.rspValid[p]         = rsp_pipe_q[p][RL-1];
      bus.wAddr[p*AW +: AW]   = waddr_q[p];
      bus.rAddr[p*AW +: AW]   = raddr_q[p];
      bus.wData[p*DW +: DW]   = wdata_q[p];
    end
    bus.rspData = bus.rData;
    bus.cflCnt  = cfl_q;
  end
endmodule

// File: tb/tb_mpram_port_sched.sv
// Bench for mpram_port_sched: behavioural RAM downstream, transaction-level
// reference model (per-port request queues, shadow memory, expected-response
// queues) compared against the DUT every cycle.
module tb_mpram_port_sched;
  localparam int MD  = 16;
  localparam int DW  = 32;
  localparam int NP  = 2;
  localparam int DEP = 4;
  localparam int RL  = 1;
  localparam int AW  = $clog2(MD);

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ram_clr = 1'b1;
  always #5 clk = ~clk;

  mpram_port_sched_if #(.MD(MD), .DW(DW), .nP(NP)) bus ();

  mpram_port_sched #(.MD(MD), .DW(DW), .nP(NP), .DEP(DEP), .RL(RL)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Behavioural RAM: one-cycle registered read, read-before-write
  logic [DW-1:0]    ram [MD];
  logic [DW*NP-1:0] ram_rd_q;
  always @(posedge clk) begin
    for (int p = 0; p < NP; p++)
      ram_rd_q[p*DW +: DW] <= ram[bus.rAddr[p*AW +: AW]];
    if (ram_clr) begin
      for (int i = 0; i < MD; i++) ram[i] <= '0;
    end else begin
      for (int p = 0; p < NP; p++)
        if (bus.wEn[p]) ram[bus.wAddr[p*AW +: AW]] <= bus.wData[p*DW +: DW];
    end
  end
  assign bus.rData = ram_rd_q;

  // Reference model state
  typedef struct { logic wr; logic [AW-1:0] addr; logic [DW-1:0] data; } req_t;
  typedef struct { int cyc; logic [DW-1:0] data; } rsp_t;
  req_t          mq [NP][$];
  rsp_t          rq [NP][$];
  logic [DW-1:0] mmem [MD];
  logic          e_wrrd [NP];
  logic          e_wen  [NP];
  logic          e_rd   [NP];
  logic [AW-1:0] e_waddr [NP];
  logic [AW-1:0] e_raddr [NP];
  logic [DW-1:0] e_wdata [NP];
  int            cfl_m;
  int            cyc;
  int            n_vec = 0;
  int            n_err = 0;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  // Compare this cycle's outputs, then advance the model across the clock edge
  task automatic model_cycle();
    logic [NP-1:0]    x_rdy, x_wrrd, x_wen;
    logic [AW*NP-1:0] x_waddr, x_raddr;
    logic [DW*NP-1:0] x_wdata;
    logic             rdy [NP];
    logic             hv  [NP];
    req_t             h   [NP];
    req_t             r;
    rsp_t             s;
    logic             st;
    logic             ev;
    for (int p = 0; p < NP; p++) begin
      x_rdy[p]              = !rst && (mq[p].size() < DEP);
      x_wrrd[p]             = e_wrrd[p];
      x_wen[p]              = e_wen[p];
      x_waddr[p*AW +: AW]   = e_waddr[p];
      x_raddr[p*AW +: AW]   = e_raddr[p];
      x_wdata[p*DW +: DW]   = e_wdata[p];
    end
    chk("reqReady", 64'(bus.reqReady), 64'(x_rdy));
    chk("wrRd",     64'(bus.wrRd),     64'(x_wrrd));
    chk("wEn",      64'(bus.wEn),      64'(x_wen));
    chk("wAddr",    64'(bus.wAddr),    64'(x_waddr));
    chk("rAddr",    64'(bus.rAddr),    64'(x_raddr));
    chk("wData",    64'(bus.wData),    64'(x_wdata));
    chk("cflCnt",   64'(bus.cflCnt),   64'(cfl_m));
    for (int p = 0; p < NP; p++) begin
      ev = (rq[p].size() > 0) && (rq[p][0].cyc == cyc);
      chk(p == 0 ? "rspValid0" : "rspValid1", 64'(bus.rspValid[p]), 64'(ev));
      if (ev) begin
        chk(p == 0 ? "rspData0" : "rspData1", 64'(bus.rspData[p*DW +: DW]), 64'(rq[p][0].data));
        void'(rq[p].pop_front());
      end
    end

    if (rst) begin
      // a write already on the RAM bus in the reset cycle still lands
      for (int p = 0; p < NP; p++) if (e_wen[p]) mmem[e_waddr[p]] = e_wdata[p];
      for (int p = 0; p < NP; p++) begin
        mq[p].delete();
        rq[p].delete();
        e_wrrd[p] = 0; e_wen[p] = 0; e_rd[p] = 0;
        e_waddr[p] = '0; e_raddr[p] = '0; e_wdata[p] = '0;
      end
      cfl_m = 0;
    end else begin
      for (int p = 0; p < NP; p++) begin
        if (e_rd[p]) begin
          s.cyc  = cyc + RL;
          s.data = mmem[e_raddr[p]];
          rq[p].push_back(s);
        end
      end
      for (int p = 0; p < NP; p++) if (e_wen[p]) mmem[e_waddr[p]] = e_wdata[p];
      for (int p = 0; p < NP; p++) begin
        rdy[p] = mq[p].size() < DEP;
        hv[p]  = mq[p].size() > 0;
        if (hv[p]) h[p] = mq[p][0];
      end
      for (int p = 0; p < NP; p++) begin
        e_wrrd[p] = 0; e_wen[p] = 0; e_rd[p] = 0;
        if (hv[p]) begin
          st = 0;
          for (int q = 0; q < p; q++)
            if (hv[q] && h[q].wr && h[p].wr && h[q].addr == h[p].addr) st = 1;
          if (st) begin
            if (cfl_m < 65535) cfl_m++;
          end else begin
            void'(mq[p].pop_front());
            e_raddr[p] = h[p].addr;
            if (h[p].wr) begin
              e_wrrd[p] = 1; e_wen[p] = 1;
              e_waddr[p] = h[p].addr; e_wdata[p] = h[p].data;
            end else begin
              e_rd[p] = 1;
            end
          end
        end
      end
      for (int p = 0; p < NP; p++) begin
        if (rdy[p] && bus.reqValid[p]) begin
          r.wr   = bus.reqWr[p];
          r.addr = bus.reqAddr[p*AW +: AW];
          r.data = bus.reqData[p*DW +: DW];
          mq[p].push_back(r);
        end
      end
    end
    cyc++;
  endtask

  task automatic step();
    @(negedge clk);
    model_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(int p, logic v, logic wr, logic [AW-1:0] a, logic [DW-1:0] d);
    bus.reqValid[p]          = v;
    bus.reqWr[p]             = wr;
    bus.reqAddr[p*AW +: AW]  = a;
    bus.reqData[p*DW +: DW]  = d;
  endtask

  task automatic idle(int n);
    for (int p = 0; p < NP; p++) drive(p, 0, 0, '0, '0);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    for (int i = 0; i < MD; i++) mmem[i] = '0;
    for (int p = 0; p < NP; p++) begin
      e_wrrd[p] = 0; e_wen[p] = 0; e_rd[p] = 0;
      e_waddr[p] = '0; e_raddr[p] = '0; e_wdata[p] = '0;
    end
    cfl_m = 0;
    cyc   = 0;
    bus.reqValid = '0; bus.reqWr = '0; bus.reqAddr = '0; bus.reqData = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    ram_clr = 1'b0;

    // reset state, then release
    step();
    rst = 1'b0;
    idle(2);

    // single read of a previously written word
    drive(0, 1, 1, 4'd5, 32'hDEADBEEF); step();
    idle(3);
    drive(0, 1, 0, 4'd5, '0); step();
    idle(5);

    // same-cycle write collision, then read back
    drive(0, 1, 1, 4'd3, 32'h11); drive(1, 1, 1, 4'd3, 32'h22); step();
    idle(4);
    drive(0, 1, 0, 4'd3, '0); step();
    idle(5);

    // port 1 backed up behind repeated port-0 collisions
    for (int i = 0; i < 10; i++) begin
      drive(0, 1, 1, 4'd3, 32'h100 + i);
      drive(1, 1, (i == 0), (i == 0) ? 4'd3 : 4'(i), 32'h200 + i);
      step();
    end
    idle(10);

    // streaming reads on both ports
    for (int i = 0; i < 8; i++) begin
      drive(0, 1, 0, 4'(i), '0);
      drive(1, 1, 0, 4'(i), '0);
      step();
    end
    idle(6);

    // reset with reads in flight
    for (int i = 0; i < 3; i++) begin drive(0, 1, 0, 4'(i), '0); step(); end
    idle(1);
    rst = 1'b1; step(); step();
    rst = 1'b0;
    idle(6);

    // randomized traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 299) == 0);
      for (int p = 0; p < NP; p++)
        drive(p, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
              ($urandom_range(0, 1) == 1) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, MD-1)),
              $urandom);
      step();
    end
    rst = 1'b0;
    idle(10);

    // saturate the stall counter: port 1 head stuck behind port-0 writes
    drive(1, 1, 1, 4'd7, 32'hCAFE);
    drive(0, 1, 1, 4'd7, 32'h0);
    step();
    drive(1, 0, 0, '0, '0);
    for (int i = 0; i < 66000; i++) begin
      drive(0, 1, 1, 4'd7, i);
      step();
    end
    chk("cfl_sat", 64'(bus.cflCnt), 64'h0000_0000_0000_FFFF);
    idle(8);
    drive(0, 1, 0, 4'd7, '0); step();
    idle(5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
